// File: rtl/prog_loader.sv
// Byte-stream program loader for the 16-bit core: assembles {hi,lo} words into a
// 16x128 program RAM, validates an XOR checksum, then serves instruction fetches.
module prog_loader #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              reload,
  input  logic [ADDR_W-1:0] pc,
  input  logic              ram_read_en,
  output logic [15:0]       instr,
  output logic              start,
  output logic              loading,
  output logic              load_done,
  output logic              load_err,
  output logic [7:0]        word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV_HI,
    S_RECV_LO,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [8:0] DEPTH_L = 9'(DEPTH);

  state_t      state_reg, state_next;
  logic [7:0]  ptr_reg;
  logic [7:0]  acc_reg;
  logic [7:0]  hi_reg;
  logic [7:0]  word_count_reg;
  logic        start_reg;
  logic [15:0] instr_reg;
  logic [15:0] mem [DEPTH];

  logic accept;
  logic count_ok;
  logic last_word;
  logic csum_ok;
  logic fetch_hit;

  assign accept    = byte_valid && byte_ready;
  assign count_ok  = (byte_in != 8'd0) && ({1'b0, byte_in} <= DEPTH_L);
  assign last_word = (ptr_reg + 8'd1) == word_count_reg;
  assign csum_ok   = byte_in == acc_reg;
  // Words past the last legal count are stale leftovers and must read as zero.
  assign fetch_hit = (state_reg == S_DONE) && (8'(pc) < word_count_reg);

  assign byte_ready = (state_reg == S_IDLE) || (state_reg == S_RECV_HI) ||
                      (state_reg == S_RECV_LO) || (state_reg == S_CHECK);
  assign loading    = (state_reg == S_RECV_HI) || (state_reg == S_RECV_LO) ||
                      (state_reg == S_CHECK);
  assign load_done  = state_reg == S_DONE;
  assign load_err   = state_reg == S_ERROR;
  assign start      = start_reg;
  assign instr      = instr_reg;
  assign word_count = word_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (accept) state_next = count_ok ? S_RECV_HI : S_ERROR;
      S_RECV_HI: if (accept) state_next = S_RECV_LO;
      S_RECV_LO: if (accept) state_next = last_word ? S_CHECK : S_RECV_HI;
      S_CHECK:   if (accept) state_next = csum_ok ? S_DONE : S_ERROR;
      S_DONE:    if (reload) state_next = S_IDLE;
      S_ERROR:   if (reload) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg        <= 8'd0;
      acc_reg        <= 8'd0;
      hi_reg         <= 8'd0;
      word_count_reg <= 8'd0;
      start_reg      <= 1'b0;
    end else begin
      start_reg <= 1'b0;
      if (accept) begin
        case (state_reg)
          S_IDLE: begin
            if (count_ok) begin
              word_count_reg <= byte_in;
              ptr_reg        <= 8'd0;
              acc_reg        <= 8'd0;
            end
          end
          S_RECV_HI: begin
            hi_reg  <= byte_in;
            acc_reg <= acc_reg ^ byte_in;
          end
          S_RECV_LO: begin
            acc_reg <= acc_reg ^ byte_in;
            ptr_reg <= ptr_reg + 8'd1;
          end
          S_CHECK: start_reg <= csum_ok;
          default: ;
        endcase
      end
    end
  end

  // RAM has no reset so it maps onto block RAM; contents survive reset and reload.
  always_ff @(posedge clk) begin
    if (accept && (state_reg == S_RECV_LO))
      mem[ptr_reg[ADDR_W-1:0]] <= {hi_reg, byte_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_reg <= 16'h0000;
    end else if (ram_read_en) begin
      instr_reg <= fetch_hit ? mem[pc] : 16'h0000;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: fixed vector table, directed corner cases,
// and random frames compared against a frame-level reference model.
module tb_prog_loader;
  localparam int DEPTH  = 128;
  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              reload;
  logic [ADDR_W-1:0] pc;
  logic              ram_read_en;
  logic [15:0]       instr;
  logic              start;
  logic              loading;
  logic              load_done;
  logic              load_err;
  logic [7:0]        word_count;

  prog_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .reload(reload), .pc(pc), .ram_read_en(ram_read_en),
    .instr(instr), .start(start), .loading(loading), .load_done(load_done),
    .load_err(load_err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;

  always @(negedge clk) if (start === 1'b1) start_cnt++;

  // Reference model: frame-level view of the loader
  logic [15:0] m_mem [DEPTH];
  int          m_wc = 0;
  bit          m_done = 0;
  bit          m_err = 0;
  int          m_starts = 0;

  typedef struct {
    logic [6:0]  pc;
    logic [15:0] exp;
  } fetch_vec_t;

  fetch_vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_instr(input int p);
    return (m_done && p < m_wc) ? m_mem[p] : 16'h0000;
  endfunction

  task automatic model_frame(input logic [7:0] f[$]);
    int n;
    logic [7:0] x;
    n = int'(f[0]);
    if (n == 0 || n > DEPTH) begin
      m_err = 1; m_done = 0;
      return;
    end
    m_wc = n;
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      m_mem[i] = {f[1 + 2*i], f[2 + 2*i]};
      x = x ^ f[1 + 2*i] ^ f[2 + 2*i];
    end
    if (f[2*n + 1] == x) begin
      m_done = 1; m_err = 0; m_starts++;
    end else begin
      m_done = 0; m_err = 1;
    end
  endtask

  task automatic make_frame(input int n, input bit bad, output logic [7:0] f[$]);
    logic [7:0] x, b;
    f = {};
    f.push_back(8'(n));
    x = 8'h00;
    for (int i = 0; i < 2*n; i++) begin
      b = 8'($urandom);
      f.push_back(b);
      x = x ^ b;
    end
    f.push_back(bad ? (x ^ 8'h5A) : x);
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit gaps);
    foreach (f[i]) begin
      if (gaps) begin
        for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
          byte_valid = 1'b0;
          byte_in    = 8'($urandom);
          reload     = 1'($urandom_range(0, 1));
          step();
        end
      end
      reload     = 1'b0;
      byte_in    = f[i];
      byte_valid = 1'b1;
      step();
    end
    byte_valid = 1'b0;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
    m_done = 0; m_err = 0;
    check("reload_ready", byte_ready, 1);
  endtask

  task automatic fetch(input int p, input logic [15:0] exp, input string name);
    pc = 7'(p);
    ram_read_en = 1'b1;
    step();
    ram_read_en = 1'b0;
    check(name, instr, exp);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_done"}, load_done, 32'(m_done));
    check({tag, "_err"}, load_err, 32'(m_err));
    check({tag, "_wc"}, word_count, 32'(m_wc));
    check({tag, "_starts"}, start_cnt, m_starts);
    check({tag, "_loading"}, loading, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, byte_ready, 1);
    check({tag, "_instr"}, instr, 0);
    check({tag, "_start"}, start, 0);
    check({tag, "_loading"}, loading, 0);
    check({tag, "_done"}, load_done, 0);
    check({tag, "_err"}, load_err, 0);
    check({tag, "_wc"}, word_count, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] rest[$];
    int n;
    bit bad;

    for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0000;
    tbl[0] = '{7'd0,   16'h1234};
    tbl[1] = '{7'd1,   16'hABCD};
    tbl[2] = '{7'd2,   16'h0000};
    tbl[3] = '{7'd127, 16'h0000};
    tbl[4] = '{7'd0,   16'h1234};

    rst = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; reload = 1'b0;
    pc = '0; ram_read_en = 1'b0;
    step(); step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // N=2 frame at one byte per cycle
    q = {8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    model_frame(q);
    rest = q[1:$];
    send_frame({q[0]}, 0);
    check("f1_loading", loading, 1);
    send_frame(rest, 0);
    check("f1_start_pulse", start, 1);
    check("f1_done_with_start", load_done, 1);
    check("f1_ready_low", byte_ready, 0);
    step();
    check("f1_start_drop", start, 0);
    check_status("f1");
    foreach (tbl[i]) fetch(int'(tbl[i].pc), tbl[i].exp, $sformatf("tbl%0d_pc%0d", i, tbl[i].pc));
    pc = 7'd1;
    step();
    check("hold_no_read_en", instr, 16'h1234);

    // Same frame, bad checksum
    do_reload();
    q = {8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    model_frame(q);
    send_frame(q, 0);
    check("f2_start_none", start, 0);
    step();
    check_status("f2");
    fetch(0, 16'h0000, "f2_fetch0");

    // Illegal counts leave word_count unchanged
    do_reload();
    q = {8'h00};
    model_frame(q);
    send_frame(q, 0);
    check_status("cnt00");
    do_reload();
    q = {8'h81};
    model_frame(q);
    send_frame(q, 0);
    check_status("cnt81");
    do_reload();
    q = {8'h01, 8'h00, 8'h07, 8'h07};
    model_frame(q);
    send_frame(q, 0);
    step();
    check_status("n1");
    fetch(0, 16'h0007, "n1_fetch0");
    fetch(1, 16'h0000, "n1_fetch1");

    // Full-depth frame
    do_reload();
    make_frame(DEPTH, 0, q);
    model_frame(q);
    send_frame(q, 0);
    step();
    check_status("n128");
    for (int p = 0; p < DEPTH; p++) fetch(p, exp_instr(p), $sformatf("n128_pc%0d", p));

    // Random frames with backpressure gaps and stray reloads
    for (int it = 0; it < 6; it++) begin
      do_reload();
      n   = (it == 0) ? 3 : $urandom_range(1, DEPTH);
      bad = (it % 3) == 2;
      make_frame(n, bad, q);
      model_frame(q);
      send_frame(q, 1);
      step();
      check_status($sformatf("rnd%0d", it));
      for (int k = 0; k < 12; k++) begin
        int p;
        p = (k < 2) ? (k == 0 ? n - 1 : n) : $urandom_range(0, DEPTH - 1);
        if (p > DEPTH - 1) p = DEPTH - 1;
        fetch(p, exp_instr(p), $sformatf("rnd%0d_pc%0d", it, p));
      end
    end

    // Abort after three data bytes
    do_reload();
    q = {8'h05, 8'h11, 8'h22, 8'h33};
    send_frame(q, 0);
    m_mem[0] = 16'h1122;
    check("abort_loading_pre", loading, 1);
    rst = 1'b1;
    #1;
    m_wc = 0; m_done = 0; m_err = 0;
    check_reset_outputs("abort");
    step();
    rst = 1'b0;
    step();
    check_status("abort_idle");

    q = {8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h00};
    q[7] = 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF ^ 8'h01 ^ 8'h02;
    model_frame(q);
    send_frame(q, 0);
    step();
    check_status("post_abort");
    for (int p = 0; p < 6; p++) fetch(p, exp_instr(p), $sformatf("post_abort_pc%0d", p));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
